// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame
// constants, parity modes and small bit-level helpers.
package uart_rx_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop

  // Parity modes, identical to the encoding used by uart_tx.
  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Two-out-of-three vote used when majority sampling is enabled.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter is expected to send for a given byte.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] data,
                                           input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input plus a
// falling-edge detector on the synchronised value. All flops reset to the
// idle (high) line level so reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Capture the pin twice, then keep one more copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: START, 8 data bits LSB first, PARITY, STOP.
// Each frame is presented as a parallel byte with a one-cycle rx_valid
// strobe; parity_err and frame_err are updated together with rx_valid and
// held, like rx_data, until the next frame completes.
// Optional build macro UART_RX_MAJORITY_EN: every bit is a 2-of-3 vote of
// the synchronised line at centre-1, centre and centre+1 (needs
// CLKS_PER_BIT >= 4); this moves each decision, and rx_valid, one clock later.
// Handshake: rx_valid is a pure strobe with no ready; the consumer must take
// rx_data/parity_err/frame_err in the cycle rx_valid is high (they stay
// stable afterwards until the next strobe).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 6000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            rx_busy,
  output rx_state_e       dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
  // The vote completes one clock after the centre, so the start-bit decision
  // is taken one count later; later bits keep the same spacing.
  localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF_BIT);
`else
  localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF_BIT - 1);
`endif

  logic             rx_s;
  logic             rx_fall;
  logic             samp;

  rx_state_e        state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_q,       bit_d;
  logic [7:0]       shift_q,     shift_d;
  logic             perr_pend_q, perr_pend_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             perr_q,      perr_d;
  logic             ferr_q,      ferr_d;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Keep the two previous synchronised samples for the 3-sample vote.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign samp = majority3(hist_q[1], hist_q[0], rx_s);
`else
  assign samp = rx_s;
`endif

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  // Next-state logic: time each bit from the start edge and sample centres.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_fall) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          if (samp) begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = samp;
          if (bit_q == LAST_BIT) begin
            state_d = ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          perr_pend_d = (samp != expected_parity(shift_q, PARITY));
          state_d     = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = perr_pend_q;
          ferr_d  = ~samp;
          // A low stop bit means a break or framing fault: wait for idle.
          state_d = samp ? ST_IDLE : ST_BREAK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Two receivers (even and odd parity) listen to the same
// serial line driven bit-accurately by the bench. Each sent frame pushes the
// expected {byte, parity_err, frame_err} for both receivers into queues; a
// monitor pops and compares on every rx_valid.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CLK_FREQ  = 6000000;
  localparam int BAUD_RATE = 9600;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;

  logic [7:0] rx_data_e, rx_data_o;
  logic       rx_valid_e, rx_valid_o;
  logic       perr_e, perr_o;
  logic       ferr_e, ferr_o;
  logic       busy_e, busy_o;
  rx_state_e  st_e, st_o;

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_e_q[$];
  logic [9:0] exp_o_q[$];
  logic [7:0] last_byte;

  // clock / reset
  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY(0)) u_dut_even (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data_e),
    .rx_valid   (rx_valid_e),
    .parity_err (perr_e),
    .frame_err  (ferr_e),
    .rx_busy    (busy_e),
    .dbg_state  (st_e)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY(1)) u_dut_odd (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data_o),
    .rx_valid   (rx_valid_o),
    .parity_err (perr_o),
    .frame_err  (ferr_o),
    .rx_busy    (busy_o),
    .dbg_state  (st_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: count ones; even parity sends a 1 when the byte has an
  // odd number of ones, odd parity sends the opposite.
  task automatic expect_frame(input logic [7:0] d, input logic p, input logic s);
    int   ones;
    logic even_bit;
    logic odd_bit;
    ones     = $countones(d);
    even_bit = (ones % 2) == 1;
    odd_bit  = !even_bit;
    exp_e_q.push_back({d, p != even_bit, !s});
    exp_o_q.push_back({d, p != odd_bit, !s});
    last_byte = d;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Send one full frame; spike_bit selects a data bit that gets a one-clock
  // inverted spike at its centre (-1 for none).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int spike_bit);
    expect_frame(d, p, s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        rx = d[i];
        repeat (HALF - 1) @(negedge clk);
        rx = ~d[i];
        @(negedge clk);
        rx = d[i];
        repeat (CPB - HALF) @(negedge clk);
      end else begin
        drive_bit(d[i]);
      end
    end
    drive_bit(p);
    drive_bit(s);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy_even"}, busy_e, 0);
    chk({tag, "_busy_odd"},  busy_o, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;

    rx    = 1'b1;
    reset = 1'b0;

    // scoreboard monitor
    fork
      forever begin
        @(negedge clk);
        if (rx_valid_e) begin
          if (exp_e_q.size() == 0) begin
            chk("even_extra_valid", rx_valid_e, 0);
          end else begin
            logic [9:0] e;
            e = exp_e_q.pop_front();
            chk("even_data", rx_data_e, e[9:2]);
            chk("even_parity_err", perr_e, e[1]);
            chk("even_frame_err", ferr_e, e[0]);
          end
        end
        if (rx_valid_o) begin
          if (exp_o_q.size() == 0) begin
            chk("odd_extra_valid", rx_valid_o, 0);
          end else begin
            logic [9:0] e;
            e = exp_o_q.pop_front();
            chk("odd_data", rx_data_o, e[9:2]);
            chk("odd_parity_err", perr_o, e[1]);
            chk("odd_frame_err", ferr_o, e[0]);
          end
        end
      end
    join_none

    // reset values
    idle(5);
    chk("rst_data_even", rx_data_e, 0);
    chk("rst_valid_even", rx_valid_e, 0);
    chk("rst_perr_even", perr_e, 0);
    chk("rst_ferr_even", ferr_e, 0);
    chk("rst_state_even", st_e, ST_IDLE);
    chk("rst_data_odd", rx_data_o, 0);
    chk("rst_state_odd", st_o, ST_IDLE);
    check_idle_outputs("rst");
    reset = 1'b1;
    idle(20);

    // 0xA5 with even parity bit and good stop
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(5);
    check_idle_outputs("after_a5");

    // 0x01 with both parity bit values
    send_frame(8'h01, 1'b1, 1'b1, -1);
    send_frame(8'h01, 1'b0, 1'b1, -1);
    idle(10);

    // 0x3C with low stop bit, then the line held low as a break
    send_frame(8'h3C, even_par(8'h3C), 1'b0, -1);
    idle(CPB);
    chk("break_busy_even", busy_e, 1);
    chk("break_busy_odd", busy_o, 1);
    idle(2 * CPB);
    rx = 1'b1;
    idle(10);
    check_idle_outputs("after_break");
    d = 8'($urandom_range(0, 255));
    p = 1'($urandom_range(0, 1));
    send_frame(d, p, 1'b1, -1);
    idle(10);

    // short low glitch on an idle line
    rx = 1'b0;
    idle(100);
    chk("glitch_busy_even", busy_e, 1);
    chk("glitch_busy_odd", busy_o, 1);
    idle(100);
    rx = 1'b1;
    idle(200);
    check_idle_outputs("after_glitch");
    idle(100);

    // back-to-back frames
    send_frame(8'h00, even_par(8'h00), 1'b1, -1);
    send_frame(8'hFF, even_par(8'hFF), 1'b1, -1);
    send_frame(8'h55, even_par(8'h55), 1'b1, -1);
    idle(10);

    // reset in the middle of a 0x81 frame; nothing is expected from it
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    chk("midframe_busy_even", busy_e, 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy_even", busy_e, 0);
    chk("midrst_busy_odd", busy_o, 0);
    chk("midrst_data_even", rx_data_e, 0);
    chk("midrst_perr_even", perr_e, 0);
    chk("midrst_ferr_odd", ferr_o, 0);
    rx = 1'b1;
    idle(10);
    reset = 1'b1;
    idle(50);
    send_frame(8'h42, even_par(8'h42), 1'b1, -1);
    idle(10);

`ifdef UART_RX_MAJORITY_EN
    // single-clock spike at the centre of data bit 3
    d = 8'($urandom_range(0, 255));
    send_frame(d, even_par(d), 1'b1, 3);
    idle(10);
`endif

    // one more random frame with a random parity bit
    d = 8'($urandom_range(0, 255));
    p = 1'($urandom_range(0, 1));
    send_frame(d, p, 1'b1, -1);

    // drain: every expected frame must have been seen
    idle(40);
    chk("pending_even", exp_e_q.size(), 0);
    chk("pending_odd", exp_o_q.size(), 0);
    chk("hold_data_even", rx_data_e, last_byte);
    chk("hold_data_odd", rx_data_o, last_byte);
    check_idle_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
